// File: rtl/rover_pkg.sv
// Shared types and constants for the rover motor-control slice.
//   stateT     : controller state encoding (also driven out on state_dbg)
//   DIR_*      : cmd_dir codes from the command source
//   MOT_*      : H-bridge IN pin patterns (IN1, IN2)
//   dirToState : maps a command direction to its steady drive state
package rover_pkg;

  typedef enum logic [2:0] {
    STOP   = 3'd0,
    FWD    = 3'd1,
    REV    = 3'd2,
    BRAKE  = 3'd3,
    BACKUP = 3'd4,
    TURN   = 3'd5
  } stateT;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_RSVD = 2'b11;

  localparam logic [1:0] MOT_FWD = 2'b10;
  localparam logic [1:0] MOT_REV = 2'b01;
  localparam logic [1:0] MOT_BRK = 2'b00;

  // The reserved direction code is deliberately folded into STOP.
  function automatic stateT dirToState(input logic [1:0] dir);
    case (dir)
      DIR_FWD: return FWD;
      DIR_REV: return REV;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Dual-channel PWM generator sharing one free-running counter.
// Each channel's active duty is reloaded only when the counter wraps to 0,
// so a duty change never produces a runt or stretched pulse mid-period.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   dutyL, dutyR   : requested duty per side (0 = always low)
//   pwmL, pwmR     : registered PWM outputs, high while counter < active duty
module pwm_gen
  import rover_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] dutyL,
  input  logic [PWM_BITS-1:0] dutyR,
  output logic                pwmL,
  output logic                pwmR
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cntNext;
  logic [PWM_BITS-1:0] activeL;
  logic [PWM_BITS-1:0] activeR;
  logic [PWM_BITS-1:0] activeLNext;
  logic [PWM_BITS-1:0] activeRNext;
  logic                wrap;

  // The output register is computed against the next counter value and the
  // next active duty, so pwmL/pwmR line up cycle-for-cycle with cnt.
  always_comb begin
    cntNext     = cnt + 1'b1;
    wrap        = (cntNext == '0);
    activeLNext = wrap ? dutyL : activeL;
    activeRNext = wrap ? dutyR : activeR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      activeL <= '0;
      activeR <= '0;
      pwmL    <= 1'b0;
      pwmR    <= 1'b0;
    end else begin
      cnt     <= cntNext;
      activeL <= activeLNext;
      activeR <= activeRNext;
      pwmL    <= (cntNext < activeLNext);
      pwmR    <= (cntNext < activeRNext);
    end
  end

endmodule

// File: rtl/crash_avoid_motor_ctrl.sv
// Rover drive controller: accepts STOP/FWD/REV commands, drives the two
// H-bridges and their enable PWMs, and runs a timed brake / back-up / spin
// manoeuvre when the (debounced) crash flag is seen while driving forward.
//
// state  | meaning
// -------+-----------------------------------------------------------
// STOP   | pins 00, duty 0, waiting for a command
// FWD    | pins 10/10 at command duty; crash flag diverts to BRAKE
// REV    | pins 01/01 at command duty; crash flag ignored
// BRAKE  | pins 00, duty 0, for BRAKE_CYC cycles
// BACKUP | pins 01/01 at AVOID_DUTY, for REVERSE_CYC cycles
// TURN   | left 01 / right 10 (spin left) at AVOID_DUTY, for TURN_CYC
//        | cycles; then BRAKE again if still crashing, else STOP
//
// Ports:
//   clk, reset          : 100 MHz clock, synchronous active-high reset
//   is_crash            : raw crash flag, asynchronous to clk
//   cmd_valid/cmd_ready : command handshake, transfer when both high
//   cmd_dir, cmd_duty   : requested direction and duty
//   motor_l, motor_r    : H-bridge IN pins per side
//   pwm_l, pwm_r        : H-bridge enable PWM per side
//   avoiding            : high during BRAKE/BACKUP/TURN
//   state_dbg           : current state encoding
module crash_avoid_motor_ctrl
  import rover_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int BRAKE_CYC    = 5_000_000,
  parameter int REVERSE_CYC  = 30_000_000,
  parameter int TURN_CYC     = 20_000_000,
  parameter int AVOID_DUTY   = 160
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                is_crash,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_dir,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic                cmd_ready,
  output logic [1:0]          motor_l,
  output logic [1:0]          motor_r,
  output logic                pwm_l,
  output logic                pwm_r,
  output logic                avoiding,
  output logic [2:0]          state_dbg
);

  localparam int                  DB_W        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam int                  TIMER_W     = 32;
  localparam logic [TIMER_W-1:0]  BRAKE_LOAD  = TIMER_W'(BRAKE_CYC - 1);
  localparam logic [TIMER_W-1:0]  BACKUP_LOAD = TIMER_W'(REVERSE_CYC - 1);
  localparam logic [TIMER_W-1:0]  TURN_LOAD   = TIMER_W'(TURN_CYC - 1);
  localparam logic [PWM_BITS-1:0] AVOID_D     = PWM_BITS'(AVOID_DUTY);

  // Crash flag synchroniser and symmetric debouncer
  logic            crashMeta;
  logic            crashSync;
  logic            crashF;
  logic            crashFNext;
  logic [DB_W-1:0] dbCnt;
  logic [DB_W-1:0] dbCntNext;

  // crashFNext is also consumed by the ready logic, which must know what
  // crashF will be on the cycle the registered cmd_ready is presented.
  always_comb begin
    crashFNext = crashF;
    dbCntNext  = '0;
    if (crashSync != crashF) begin
      if (dbCnt == DB_LAST) begin
        crashFNext = crashSync;
      end else begin
        dbCntNext = dbCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crashMeta <= 1'b0;
      crashSync <= 1'b0;
      crashF    <= 1'b0;
      dbCnt     <= '0;
    end else begin
      crashMeta <= is_crash;
      crashSync <= crashMeta;
      crashF    <= crashFNext;
      dbCnt     <= dbCntNext;
    end
  end

  // Control FSM
  stateT               state;
  stateT               stateNext;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timerNext;
  logic [PWM_BITS-1:0] cmdDuty;
  logic [PWM_BITS-1:0] cmdDutyNext;
  logic                accept;

  always_comb begin
    stateNext   = state;
    timerNext   = timer;
    cmdDutyNext = cmdDuty;
    accept      = cmd_valid && cmd_ready;
    case (state)
      STOP, REV: begin
        if (accept) begin
          stateNext   = dirToState(cmd_dir);
          cmdDutyNext = cmd_duty;
        end
      end
      FWD: begin
        if (crashF) begin
          stateNext = BRAKE;
          timerNext = BRAKE_LOAD;
        end else if (accept) begin
          stateNext   = dirToState(cmd_dir);
          cmdDutyNext = cmd_duty;
        end
      end
      BRAKE: begin
        if (timer == '0) begin
          stateNext = BACKUP;
          timerNext = BACKUP_LOAD;
        end else begin
          timerNext = timer - 1'b1;
        end
      end
      BACKUP: begin
        if (timer == '0) begin
          stateNext = TURN;
          timerNext = TURN_LOAD;
        end else begin
          timerNext = timer - 1'b1;
        end
      end
      TURN: begin
        if (timer == '0) begin
          if (crashF) begin
            stateNext = BRAKE;
            timerNext = BRAKE_LOAD;
          end else begin
            stateNext = STOP;
          end
        end else begin
          timerNext = timer - 1'b1;
        end
      end
      default: begin
        stateNext = STOP;
      end
    endcase
  end

  // Output registers are decoded from the next state so pins, duty request,
  // avoiding and cmd_ready all change on the same edge as the state.
  logic [1:0]          motorLNext;
  logic [1:0]          motorRNext;
  logic [PWM_BITS-1:0] dutyNext;
  logic [PWM_BITS-1:0] dutyQ;
  logic                avoidNext;
  logic                readyNext;

  always_comb begin
    motorLNext = MOT_BRK;
    motorRNext = MOT_BRK;
    dutyNext   = '0;
    avoidNext  = 1'b0;
    case (stateNext)
      FWD: begin
        motorLNext = MOT_FWD;
        motorRNext = MOT_FWD;
        dutyNext   = cmdDutyNext;
      end
      REV: begin
        motorLNext = MOT_REV;
        motorRNext = MOT_REV;
        dutyNext   = cmdDutyNext;
      end
      BRAKE: begin
        avoidNext = 1'b1;
      end
      BACKUP: begin
        motorLNext = MOT_REV;
        motorRNext = MOT_REV;
        dutyNext   = AVOID_D;
        avoidNext  = 1'b1;
      end
      TURN: begin
        motorLNext = MOT_REV;
        motorRNext = MOT_FWD;
        dutyNext   = AVOID_D;
        avoidNext  = 1'b1;
      end
      default: ;
    endcase
    readyNext = (stateNext == STOP) || (stateNext == REV) ||
                ((stateNext == FWD) && !crashFNext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STOP;
      timer     <= '0;
      cmdDuty   <= '0;
      motor_l   <= MOT_BRK;
      motor_r   <= MOT_BRK;
      dutyQ     <= '0;
      avoiding  <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      cmdDuty   <= cmdDutyNext;
      motor_l   <= motorLNext;
      motor_r   <= motorRNext;
      dutyQ     <= dutyNext;
      avoiding  <= avoidNext;
      cmd_ready <= readyNext;
    end
  end

  assign state_dbg = state;

  // Both sides always run at the same duty; separate inputs keep pwm_gen
  // ready for differential steering later.
  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) uPwm (
    .clk  (clk),
    .reset(reset),
    .dutyL(dutyQ),
    .dutyR(dutyQ),
    .pwmL (pwm_l),
    .pwmR (pwm_r)
  );

endmodule

// File: tb/tb_crash_avoid_motor_ctrl.sv
module tb_crash_avoid_motor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       is_crash;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [7:0] cmd_duty;
  logic       cmd_ready;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       pwm_l;
  logic       pwm_r;
  logic       avoiding;
  logic [2:0] state_dbg;

  int compared   = 0;
  int mismatched = 0;

  // Reference PWM counter: cleared by reset, free-running otherwise.
  logic [7:0] mcnt;

  crash_avoid_motor_ctrl #(
    .PWM_BITS    (8),
    .DEBOUNCE_CYC(4),
    .BRAKE_CYC   (10),
    .REVERSE_CYC (20),
    .TURN_CYC    (15),
    .AVOID_DUTY  (160)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .is_crash (is_crash),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_duty (cmd_duty),
    .cmd_ready(cmd_ready),
    .motor_l  (motor_l),
    .motor_r  (motor_r),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .avoiding (avoiding),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) mcnt <= 8'd0;
    else       mcnt <= mcnt + 8'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the next period start, then records one full PWM period.
  task automatic measure_pwm(input int duty, output int highL, output int highR,
                             output int shapeErr, output int readyErr);
    highL = 0; highR = 0; shapeErr = 0; readyErr = 0;
    step(1);
    for (int i = 0; i < 300 && mcnt != 8'd0; i++) step(1);
    for (int i = 0; i < 256; i++) begin
      if (pwm_l === 1'b1) highL++;
      if (pwm_r === 1'b1) highR++;
      if (pwm_l !== (int'(mcnt) < duty)) shapeErr++;
      if (cmd_ready !== 1'b1) readyErr++;
      step(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; is_crash = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_duty = 8'd0;
    step(3);
    compared++;
    if (state_dbg !== 3'd0 || motor_l !== 2'b00 || motor_r !== 2'b00 || pwm_l !== 1'b0 ||
        pwm_r !== 1'b0 || avoiding !== 1'b0 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got st=%0d ml=%b mr=%b pwm=%b%b av=%b rdy=%b, want st=0 ml=00 mr=00 pwm=00 av=0 rdy=0",
               state_dbg, motor_l, motor_r, pwm_l, pwm_r, avoiding, cmd_ready);
    end
    reset = 1'b0;
    step(1);
    compared++;
    if (cmd_ready !== 1'b1 || state_dbg !== 3'd0) begin
      mismatched++;
      $display("FAIL ready_after_reset: got rdy=%b st=%0d, want rdy=1 st=0", cmd_ready, state_dbg);
    end
  endtask

  task automatic test_fwd_pwm;
    int hl, hr, se, re;
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_duty = 8'd64;
    step(1);
    cmd_valid = 1'b0;
    compared++;
    if (state_dbg !== 3'd1 || motor_l !== 2'b10 || motor_r !== 2'b10) begin
      mismatched++;
      $display("FAIL fwd_pins: got st=%0d ml=%b mr=%b, want st=1 ml=10 mr=10", state_dbg, motor_l, motor_r);
    end
    measure_pwm(64, hl, hr, se, re);
    compared++;
    if (hl != 64 || hr != 64) begin
      mismatched++;
      $display("FAIL fwd_duty64_width: got L=%0d R=%0d high, want 64/64", hl, hr);
    end
    compared++;
    if (se != 0) begin
      mismatched++;
      $display("FAIL fwd_duty64_shape: got %0d misplaced cycles, want 0", se);
    end
    compared++;
    if (re != 0) begin
      mismatched++;
      $display("FAIL fwd_ready_throughout: got %0d cycles ready!=1, want 0", re);
    end
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_duty = 8'd255;
    step(1);
    cmd_valid = 1'b0;
    measure_pwm(255, hl, hr, se, re);
    compared++;
    if (hl != 255 || se != 0) begin
      mismatched++;
      $display("FAIL duty255: got %0d high, %0d misplaced, want 255 high, 0 misplaced", hl, se);
    end
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_duty = 8'd0;
    step(1);
    cmd_valid = 1'b0;
    measure_pwm(0, hl, hr, se, re);
    compared++;
    if (hl != 0 || hr != 0) begin
      mismatched++;
      $display("FAIL duty0: got L=%0d R=%0d high, want 0/0", hl, hr);
    end
  endtask

  task automatic test_debounce_pulse;
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_duty = 8'd64;
    step(1);
    cmd_valid = 1'b0;
    is_crash = 1'b1;
    step(3);
    is_crash = 1'b0;
    step(10);
    compared++;
    if (state_dbg !== 3'd1 || motor_l !== 2'b10 || motor_r !== 2'b10 || avoiding !== 1'b0) begin
      mismatched++;
      $display("FAIL debounce_pulse: got st=%0d ml=%b mr=%b av=%b, want st=1 ml=10 mr=10 av=0",
               state_dbg, motor_l, motor_r, avoiding);
    end
  endtask

  task automatic test_crash_manoeuvre;
    is_crash = 1'b1;
    step(6);
    compared++;
    if (state_dbg !== 3'd1 || motor_l !== 2'b10) begin
      mismatched++;
      $display("FAIL crash_latency_early: got st=%0d ml=%b after 6 cycles, want st=1 ml=10", state_dbg, motor_l);
    end
    step(1);
    compared++;
    if (state_dbg !== 3'd3 || motor_l !== 2'b00 || motor_r !== 2'b00 || avoiding !== 1'b1 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL brake_entry: got st=%0d ml=%b mr=%b av=%b rdy=%b, want st=3 ml=00 mr=00 av=1 rdy=0",
               state_dbg, motor_l, motor_r, avoiding, cmd_ready);
    end
    step(9);
    compared++;
    if (state_dbg !== 3'd3) begin
      mismatched++;
      $display("FAIL brake_last: got st=%0d, want 3", state_dbg);
    end
    step(1);
    compared++;
    if (state_dbg !== 3'd4 || motor_l !== 2'b01 || motor_r !== 2'b01) begin
      mismatched++;
      $display("FAIL backup_entry: got st=%0d ml=%b mr=%b, want st=4 ml=01 mr=01", state_dbg, motor_l, motor_r);
    end
    is_crash = 1'b0;
    step(19);
    compared++;
    if (state_dbg !== 3'd4) begin
      mismatched++;
      $display("FAIL backup_last: got st=%0d, want 4", state_dbg);
    end
    step(1);
    compared++;
    if (state_dbg !== 3'd5 || motor_l !== 2'b01 || motor_r !== 2'b10 || avoiding !== 1'b1) begin
      mismatched++;
      $display("FAIL turn_entry: got st=%0d ml=%b mr=%b av=%b, want st=5 ml=01 mr=10 av=1",
               state_dbg, motor_l, motor_r, avoiding);
    end
    step(14);
    compared++;
    if (state_dbg !== 3'd5) begin
      mismatched++;
      $display("FAIL turn_last: got st=%0d, want 5", state_dbg);
    end
    step(1);
    compared++;
    if (state_dbg !== 3'd0 || motor_l !== 2'b00 || motor_r !== 2'b00 || avoiding !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL turn_exit_stop: got st=%0d ml=%b mr=%b av=%b rdy=%b, want st=0 ml=00 mr=00 av=0 rdy=1",
               state_dbg, motor_l, motor_r, avoiding, cmd_ready);
    end
    step(5);
    compared++;
    if (state_dbg !== 3'd0) begin
      mismatched++;
      $display("FAIL stop_holds: got st=%0d, want 0", state_dbg);
    end
  endtask

  task automatic test_crash_repeat;
    int readyErr = 0;
    int stateErr = 0;
    is_crash = 1'b1;
    step(8);
    compared++;
    if (state_dbg !== 3'd0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stop_ignores_crash: got st=%0d rdy=%b, want st=0 rdy=1", state_dbg, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_duty = 8'd90;
    step(1);
    cmd_dir = 2'b10; cmd_duty = 8'd33;
    compared++;
    if (state_dbg !== 3'd1 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL fwd_accept_under_crash: got st=%0d rdy=%b, want st=1 rdy=0", state_dbg, cmd_ready);
    end
    step(1);
    compared++;
    if (state_dbg !== 3'd3) begin
      mismatched++;
      $display("FAIL fwd_to_brake_priority: got st=%0d, want 3", state_dbg);
    end
    for (int i = 0; i < 45; i++) begin
      if (cmd_ready !== 1'b0) readyErr++;
      if (state_dbg !== 3'd3 && state_dbg !== 3'd4 && state_dbg !== 3'd5) stateErr++;
      step(1);
    end
    compared++;
    if (readyErr != 0 || stateErr != 0) begin
      mismatched++;
      $display("FAIL manoeuvre_blocks_cmd: got %0d ready-high, %0d non-avoid cycles, want 0/0", readyErr, stateErr);
    end
    compared++;
    if (state_dbg !== 3'd3 || motor_l !== 2'b00) begin
      mismatched++;
      $display("FAIL turn_repeat_brake: got st=%0d ml=%b, want st=3 ml=00", state_dbg, motor_l);
    end
  endtask

  task automatic test_reset_mid_turn;
    for (int i = 0; i < 100 && state_dbg !== 3'd5; i++) step(1);
    compared++;
    if (state_dbg !== 3'd5) begin
      mismatched++;
      $display("FAIL reach_turn: got st=%0d after 100 cycles, want 5", state_dbg);
    end
    step(3);
    reset = 1'b1; cmd_valid = 1'b0; is_crash = 1'b0;
    step(1);
    compared++;
    if (state_dbg !== 3'd0 || motor_l !== 2'b00 || motor_r !== 2'b00 || pwm_l !== 1'b0 ||
        pwm_r !== 1'b0 || avoiding !== 1'b0 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_turn: got st=%0d ml=%b mr=%b pwm=%b%b av=%b rdy=%b, want st=0 ml=00 mr=00 pwm=00 av=0 rdy=0",
               state_dbg, motor_l, motor_r, pwm_l, pwm_r, avoiding, cmd_ready);
    end
    step(2);
    reset = 1'b0;
    step(1);
    compared++;
    if (state_dbg !== 3'd0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL after_mid_turn_reset: got st=%0d rdy=%b, want st=0 rdy=1", state_dbg, cmd_ready);
    end
  endtask

  task automatic test_rev_duty_change;
    int oldErr = 0;
    int newErr = 0;
    int highs  = 0;
    is_crash = 1'b1;
    cmd_valid = 1'b1; cmd_dir = 2'b10; cmd_duty = 8'd200;
    step(1);
    cmd_valid = 1'b0;
    step(20);
    compared++;
    if (state_dbg !== 3'd2 || motor_l !== 2'b01 || motor_r !== 2'b01 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rev_ignores_crash: got st=%0d ml=%b mr=%b rdy=%b, want st=2 ml=01 mr=01 rdy=1",
               state_dbg, motor_l, motor_r, cmd_ready);
    end
    step(1);
    for (int i = 0; i < 300 && mcnt != 8'd0; i++) step(1);
    for (int i = 0; i < 300 && mcnt != 8'd100; i++) step(1);
    cmd_valid = 1'b1; cmd_dir = 2'b10; cmd_duty = 8'd50;
    step(1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && mcnt != 8'd0; i++) begin
      if (pwm_l !== (int'(mcnt) < 200)) oldErr++;
      step(1);
    end
    for (int i = 0; i < 256; i++) begin
      if (pwm_l === 1'b1) highs++;
      if (pwm_l !== (int'(mcnt) < 50)) newErr++;
      step(1);
    end
    compared++;
    if (oldErr != 0) begin
      mismatched++;
      $display("FAIL duty_change_old_period: got %0d cycles off the 200 shape, want 0", oldErr);
    end
    compared++;
    if (newErr != 0 || highs != 50) begin
      mismatched++;
      $display("FAIL duty_change_new_period: got %0d high, %0d misplaced, want 50 high, 0 misplaced", highs, newErr);
    end
    compared++;
    if (state_dbg !== 3'd2) begin
      mismatched++;
      $display("FAIL rev_stays: got st=%0d, want 2", state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_pwm();
    test_debounce_pulse();
    test_crash_manoeuvre();
    test_crash_repeat();
    test_reset_mid_turn();
    test_rev_duty_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
